// File: rtl/apu_pkg.sv
// Shared types and limits for the address patch unit (addr_patch_unit).
package apu_pkg;

  localparam int MAX_PATCH = 16;

  // Per-entry control flags; the address-wide fields live in the top's entry struct
  // because their width follows the top's ADDR_W parameter.
  typedef struct packed {
    logic en;
    logic oneshot;
  } patch_flags_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apu_match.sv
// Combinational priority comparator: finds the lowest enabled entry whose
// match address equals the request address.
module apu_match #(
  parameter int ADDR_W    = 32,
  parameter int NUM_PATCH = 4,
  parameter int IDX_W     = 2
) (
  input  logic [ADDR_W-1:0]                 addr_i,
  input  logic [NUM_PATCH-1:0][ADDR_W-1:0]  match_addr_i,
  input  logic [NUM_PATCH-1:0]              en_i,
  output logic                              hit_o,
  output logic [IDX_W-1:0]                  idx_o
);

  // Scan from the top down so the lowest hitting index is written last and wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_PATCH - 1; i >= 0; i--) begin
      if (en_i[i] && (match_addr_i[i] == addr_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/addr_patch_unit.sv
// Address patch stage: replaces request addresses that hit a programmable entry,
// then registers the result in one valid/ready stage. Optional hit counter: APU_HIT_CNT_EN.
module addr_patch_unit
  import apu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_PATCH = 4,
`ifdef APU_HIT_CNT_EN
  parameter int CNT_W     = 16,
`endif
  localparam int IDX_W    = idx_width(NUM_PATCH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 si_valid_i,
  output logic                 si_ready_o,
  input  logic [ADDR_W-1:0]    si_addr_i,
  output logic                 mi_valid_o,
  input  logic                 mi_ready_i,
  output logic [ADDR_W-1:0]    mi_addr_o,
  output logic                 mi_patched_o,
  output logic [IDX_W-1:0]     mi_patch_idx_o,
  input  logic                 ctl_pat_we_i,
  input  logic [IDX_W-1:0]     ctl_pat_idx_i,
  input  logic [ADDR_W-1:0]    ctl_pat_addr_i,
  input  logic [ADDR_W-1:0]    ctl_pat_data_i,
  input  logic                 ctl_pat_en_i,
  input  logic                 ctl_pat_oneshot_i,
`ifdef APU_HIT_CNT_EN
  input  logic                 ctl_hit_clr_i,
  output logic [CNT_W-1:0]     ctl_hit_cnt_o,
`endif
  output logic [NUM_PATCH-1:0] ctl_pat_valid_o
);

  if (NUM_PATCH < 1 || NUM_PATCH > MAX_PATCH) begin : g_param_check
    $error("addr_patch_unit: NUM_PATCH out of range");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] data;
    patch_flags_t      flags;
  } patch_entry_t;

  patch_entry_t [NUM_PATCH-1:0] ent_q, ent_d;

  logic [NUM_PATCH-1:0][ADDR_W-1:0] match_addr;
  logic [NUM_PATCH-1:0]             en_vec;
  logic                             hit;
  logic [IDX_W-1:0]                 hit_idx;
  logic [ADDR_W-1:0]                hit_data;
  logic                             accept;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_patched_q, out_patched_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;

  always_comb begin
    match_addr = '0;
    en_vec     = '0;
    for (int i = 0; i < NUM_PATCH; i++) begin
      match_addr[i] = ent_q[i].addr;
      en_vec[i]     = ent_q[i].flags.en;
    end
  end

  apu_match #(
    .ADDR_W    (ADDR_W),
    .NUM_PATCH (NUM_PATCH),
    .IDX_W     (IDX_W)
  ) u_match (
    .addr_i       (si_addr_i),
    .match_addr_i (match_addr),
    .en_i         (en_vec),
    .hit_o        (hit),
    .idx_o        (hit_idx)
  );

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < NUM_PATCH; i++) begin
      if (hit_idx == IDX_W'(i)) hit_data = ent_q[i].data;
    end
  end

  // Handshake: a request transfers when si_valid_i && si_ready_o; the output
  // transfers when mi_valid_o && mi_ready_i, and mi_* hold while stalled.
  assign si_ready_o = !out_valid_q || mi_ready_i;
  assign accept     = si_valid_i && si_ready_o;

  // Control write is applied after the one-shot clear so it wins on collision.
  // Indices beyond NUM_PATCH match no slot and are dropped.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < NUM_PATCH; i++) begin
      if (accept && hit && (hit_idx == IDX_W'(i)) && ent_q[i].flags.oneshot) begin
        ent_d[i].flags.en = 1'b0;
      end
      if (ctl_pat_we_i && (ctl_pat_idx_i == IDX_W'(i))) begin
        ent_d[i].addr          = ctl_pat_addr_i;
        ent_d[i].data          = ctl_pat_data_i;
        ent_d[i].flags.en      = ctl_pat_en_i;
        ent_d[i].flags.oneshot = ctl_pat_oneshot_i;
      end
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_addr_d    = out_addr_q;
    out_patched_d = out_patched_q;
    out_idx_d     = out_idx_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_addr_d    = hit ? hit_data : si_addr_i;
      out_patched_d = hit;
      out_idx_d     = hit_idx;
    end else if (mi_ready_i) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_q         <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
      out_patched_q <= 1'b0;
      out_idx_q     <= '0;
    end else begin
      ent_q         <= ent_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_patched_q <= out_patched_d;
      out_idx_q     <= out_idx_d;
    end
  end

  assign mi_valid_o      = out_valid_q;
  assign mi_addr_o       = out_addr_q;
  assign mi_patched_o    = out_patched_q;
  assign mi_patch_idx_o  = out_idx_q;
  assign ctl_pat_valid_o = en_vec;

`ifdef APU_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  // Saturating count of accepted hits; clear dominates a coincident hit.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (ctl_hit_clr_i) begin
      hit_cnt_d = '0;
    end else if (accept && hit && !(&hit_cnt_q)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hit_cnt_q <= '0;
    else       hit_cnt_q <= hit_cnt_d;
  end

  assign ctl_hit_cnt_o = hit_cnt_q;
`endif

endmodule

// File: tb/tb_addr_patch_unit.sv
// Self-checking bench for addr_patch_unit: scoreboard of expected output beats
// compared against beats captured from the master-side port.
module tb_addr_patch_unit;

  localparam int ADDR_W    = 32;
  localparam int NUM_PATCH = 4;
  localparam int IDX_W     = 2;
  localparam int E_W       = 1 + IDX_W + ADDR_W;

  logic                 clk;
  logic                 rst_i;
  logic                 si_valid_i;
  logic                 si_ready_o;
  logic [ADDR_W-1:0]    si_addr_i;
  logic                 mi_valid_o;
  logic                 mi_ready_i;
  logic [ADDR_W-1:0]    mi_addr_o;
  logic                 mi_patched_o;
  logic [IDX_W-1:0]     mi_patch_idx_o;
  logic                 ctl_pat_we_i;
  logic [IDX_W-1:0]     ctl_pat_idx_i;
  logic [ADDR_W-1:0]    ctl_pat_addr_i;
  logic [ADDR_W-1:0]    ctl_pat_data_i;
  logic                 ctl_pat_en_i;
  logic                 ctl_pat_oneshot_i;
  logic [NUM_PATCH-1:0] ctl_pat_valid_o;
`ifdef APU_HIT_CNT_EN
  logic                 ctl_hit_clr_i;
  logic [1:0]           ctl_hit_cnt_o;
`endif

  addr_patch_unit #(
    .ADDR_W    (ADDR_W),
`ifdef APU_HIT_CNT_EN
    .CNT_W     (2),
`endif
    .NUM_PATCH (NUM_PATCH)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .si_valid_i        (si_valid_i),
    .si_ready_o        (si_ready_o),
    .si_addr_i         (si_addr_i),
    .mi_valid_o        (mi_valid_o),
    .mi_ready_i        (mi_ready_i),
    .mi_addr_o         (mi_addr_o),
    .mi_patched_o      (mi_patched_o),
    .mi_patch_idx_o    (mi_patch_idx_o),
    .ctl_pat_we_i      (ctl_pat_we_i),
    .ctl_pat_idx_i     (ctl_pat_idx_i),
    .ctl_pat_addr_i    (ctl_pat_addr_i),
    .ctl_pat_data_i    (ctl_pat_data_i),
    .ctl_pat_en_i      (ctl_pat_en_i),
    .ctl_pat_oneshot_i (ctl_pat_oneshot_i),
`ifdef APU_HIT_CNT_EN
    .ctl_hit_clr_i     (ctl_hit_clr_i),
    .ctl_hit_cnt_o     (ctl_hit_cnt_o),
`endif
    .ctl_pat_valid_o   (ctl_pat_valid_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] got_q[$];
  int  n_checks;
  int  n_pass;
  bit  rand_mode;

  logic [ADDR_W-1:0] mdl_addr [NUM_PATCH];
  logic [ADDR_W-1:0] mdl_data [NUM_PATCH];
  bit                mdl_en   [NUM_PATCH];
  bit                mdl_os   [NUM_PATCH];

  // Output monitor: a beat transfers at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst_i && mi_valid_o && mi_ready_i)
      got_q.push_back({mi_patched_o, mi_patch_idx_o, mi_addr_o});
  end

  function automatic logic [E_W-1:0] mk(input bit p, input int idx, input logic [ADDR_W-1:0] a);
    return {p, IDX_W'(idx), a};
  endfunction

  // Driver tasks
  task automatic apply_reset();
    rst_i             = 1'b1;
    si_valid_i        = 1'b0;
    si_addr_i         = '0;
    mi_ready_i        = 1'b1;
    ctl_pat_we_i      = 1'b0;
    ctl_pat_idx_i     = '0;
    ctl_pat_addr_i    = '0;
    ctl_pat_data_i    = '0;
    ctl_pat_en_i      = 1'b0;
    ctl_pat_oneshot_i = 1'b0;
`ifdef APU_HIT_CNT_EN
    ctl_hit_clr_i     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < NUM_PATCH; i++) begin
      mdl_addr[i] = '0; mdl_data[i] = '0; mdl_en[i] = 0; mdl_os[i] = 0;
    end
  endtask

  task automatic write_entry(input int idx, input logic [ADDR_W-1:0] a,
                             input logic [ADDR_W-1:0] d, input bit en, input bit os);
    ctl_pat_we_i      = 1'b1;
    ctl_pat_idx_i     = IDX_W'(idx);
    ctl_pat_addr_i    = a;
    ctl_pat_data_i    = d;
    ctl_pat_en_i      = en;
    ctl_pat_oneshot_i = os;
    @(posedge clk);
    #1;
    ctl_pat_we_i = 1'b0;
    mdl_addr[idx] = a; mdl_data[idx] = d; mdl_en[idx] = en; mdl_os[idx] = os;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [E_W-1:0] e);
    bit acc;
    acc = 0;
    si_valid_i = 1'b1;
    si_addr_i  = a;
    exp_q.push_back(e);
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = si_ready_o;
      @(posedge clk);
      #1;
      if (rand_mode) mi_ready_i = ($urandom_range(0, 3) != 0);
    end
    si_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: addr %h not accepted, required acceptance within 100 cycles", a);
    end
  endtask

  task automatic drain();
    mi_ready_i = 1'b1;
    for (int k = 0; k < 200 && got_q.size() < exp_q.size(); k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // Tests
  task automatic test_reset();
    apply_reset();
    n_checks++; if (mi_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", mi_valid_o); else n_pass++;
    n_checks++; if (mi_addr_o !== '0) $display("FAIL reset_addr: got %h want 0", mi_addr_o); else n_pass++;
    n_checks++; if (mi_patched_o !== 1'b0) $display("FAIL reset_patched: got %b want 0", mi_patched_o); else n_pass++;
    n_checks++; if (mi_patch_idx_o !== '0) $display("FAIL reset_idx: got %0d want 0", mi_patch_idx_o); else n_pass++;
    n_checks++; if (ctl_pat_valid_o !== '0) $display("FAIL reset_pat_valid: got %b want 0", ctl_pat_valid_o); else n_pass++;
    n_checks++; if (si_ready_o !== 1'b1) $display("FAIL reset_si_ready: got %b want 1", si_ready_o); else n_pass++;
`ifdef APU_HIT_CNT_EN
    n_checks++; if (ctl_hit_cnt_o !== '0) $display("FAIL reset_hit_cnt: got %0d want 0", ctl_hit_cnt_o); else n_pass++;
`endif
  endtask

  task automatic test_passthrough();
    logic [E_W-1:0] e, g;
    apply_reset();
    send(32'h1000, mk(0, 0, 32'h1000));
    // One cycle after acceptance the result is already on the output.
    n_checks++; if (mi_valid_o !== 1'b1) $display("FAIL latency_valid: got %b want 1", mi_valid_o); else n_pass++;
    n_checks++; if (mi_addr_o !== 32'h1000) $display("FAIL latency_addr: got %h want 00001000", mi_addr_o); else n_pass++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL passthrough_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL passthrough: got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_hit_priority();
    logic [E_W-1:0] e, g;
    apply_reset();
    write_entry(2, 32'h1000, 32'h8000, 1, 0);
    write_entry(1, 32'h2000, 32'h000A, 1, 0);
    write_entry(3, 32'h2000, 32'h000B, 1, 0);
    send(32'h1000, mk(1, 2, 32'h8000));
    send(32'h1004, mk(0, 0, 32'h1004));
    send(32'h2000, mk(1, 1, 32'h000A));
    write_entry(1, 32'h2000, 32'h000A, 0, 0);
    send(32'h2000, mk(1, 3, 32'h000B));
    drain();
    n_checks++; if (ctl_pat_valid_o !== 4'b1100) $display("FAIL hit_pat_valid: got %b want 1100", ctl_pat_valid_o); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL hit_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL hit_priority: got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_oneshot();
    logic [E_W-1:0] e, g;
    apply_reset();
    write_entry(0, 32'h3000, 32'h5000, 1, 1);
    send(32'h3000, mk(1, 0, 32'h5000));
    send(32'h3000, mk(0, 0, 32'h3000));
    drain();
    n_checks++; if (ctl_pat_valid_o !== 4'b0000) $display("FAIL oneshot_pat_valid: got %b want 0000", ctl_pat_valid_o); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL oneshot_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL oneshot: got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_write_timing();
    logic [E_W-1:0] e, g;
    apply_reset();
    write_entry(0, 32'h3000, 32'h5000, 1, 1);
    // One-shot hit and rewrite of the same entry in one cycle: old data used, write wins.
    si_valid_i = 1'b1; si_addr_i = 32'h3000;
    ctl_pat_we_i = 1'b1; ctl_pat_idx_i = 2'd0; ctl_pat_addr_i = 32'h3000;
    ctl_pat_data_i = 32'h6000; ctl_pat_en_i = 1'b1; ctl_pat_oneshot_i = 1'b1;
    exp_q.push_back(mk(1, 0, 32'h5000));
    @(posedge clk); #1;
    si_valid_i = 1'b0; ctl_pat_we_i = 1'b0;
    n_checks++; if (ctl_pat_valid_o[0] !== 1'b1) $display("FAIL write_wins: got %b want 1", ctl_pat_valid_o[0]); else n_pass++;
    // A new entry is not visible to a request in its own write cycle.
    si_valid_i = 1'b1; si_addr_i = 32'h4000;
    ctl_pat_we_i = 1'b1; ctl_pat_idx_i = 2'd1; ctl_pat_addr_i = 32'h4000;
    ctl_pat_data_i = 32'h7000; ctl_pat_en_i = 1'b1; ctl_pat_oneshot_i = 1'b0;
    exp_q.push_back(mk(0, 0, 32'h4000));
    @(posedge clk); #1;
    si_valid_i = 1'b0; ctl_pat_we_i = 1'b0;
    send(32'h4000, mk(1, 1, 32'h7000));
    send(32'h3000, mk(1, 0, 32'h6000));
    drain();
    n_checks++; if (ctl_pat_valid_o !== 4'b0010) $display("FAIL write_pat_valid: got %b want 0010", ctl_pat_valid_o); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL write_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL write_timing: got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [E_W-1:0] e, g, a_exp;
    bit acc;
    apply_reset();
    write_entry(2, 32'h1000, 32'h8000, 1, 0);
    mi_ready_i = 1'b0;
    a_exp = mk(1, 2, 32'h8000);
    send(32'h1000, a_exp);
    si_valid_i = 1'b1; si_addr_i = 32'h1004;
    exp_q.push_back(mk(0, 0, 32'h1004));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (si_ready_o !== 1'b0) $display("FAIL stall_si_ready: cycle %0d got %b want 0", c, si_ready_o); else n_pass++;
      n_checks++;
      if ({mi_valid_o, mi_patched_o, mi_patch_idx_o, mi_addr_o} !== {1'b1, a_exp})
        $display("FAIL stall_hold: cycle %0d got %h want %h", c, {mi_valid_o, mi_patched_o, mi_patch_idx_o, mi_addr_o}, {1'b1, a_exp});
      else n_pass++;
      @(posedge clk); #1;
    end
    mi_ready_i = 1'b1;
    acc = 0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk); acc = si_ready_o;
      @(posedge clk); #1;
    end
    si_valid_i = 1'b0;
    drain();
    n_checks++; if (got_q.size() != 2) $display("FAIL stall_count: got %0d beats want 2", got_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL stall_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL stall_order: got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_random_traffic();
    logic [E_W-1:0] e, g;
    logic [ADDR_W-1:0] a;
    logic [NUM_PATCH-1:0] mdl_vec;
    bit hit;
    apply_reset();
    write_entry(0, 32'h100, 32'hF00, 1, 1);
    write_entry(1, 32'h104, 32'hF04, 1, 0);
    write_entry(2, 32'h108, 32'hF08, 1, 1);
    write_entry(3, 32'h104, 32'hF0C, 1, 0);
    rand_mode = 1;
    for (int t = 0; t < 40; t++) begin
      a = 32'h100 + 32'($urandom_range(0, 4)) * 4;
      hit = 0;
      e = mk(0, 0, a);
      for (int i = 0; i < NUM_PATCH && !hit; i++) begin
        if (mdl_en[i] && mdl_addr[i] == a) begin
          hit = 1;
          e = mk(1, i, mdl_data[i]);
          if (mdl_os[i]) mdl_en[i] = 0;
        end
      end
      send(a, e);
    end
    rand_mode = 0;
    drain();
    for (int i = 0; i < NUM_PATCH; i++) mdl_vec[i] = mdl_en[i];
    n_checks++; if (ctl_pat_valid_o !== mdl_vec) $display("FAIL random_pat_valid: got %b want %b", ctl_pat_valid_o, mdl_vec); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL random_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL random_beat: got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    write_entry(1, 32'h2000, 32'h000A, 1, 0);
    mi_ready_i = 1'b0;
    send(32'h2000, mk(1, 1, 32'h000A));
    rst_i = 1'b1;
    #1;
    n_checks++; if (mi_valid_o !== 1'b0) $display("FAIL midrst_valid: got %b want 0", mi_valid_o); else n_pass++;
    n_checks++; if (mi_addr_o !== '0) $display("FAIL midrst_addr: got %h want 0", mi_addr_o); else n_pass++;
    n_checks++; if (ctl_pat_valid_o !== '0) $display("FAIL midrst_pat_valid: got %b want 0", ctl_pat_valid_o); else n_pass++;
    apply_reset();
  endtask

`ifdef APU_HIT_CNT_EN
  task automatic test_hit_counter();
    apply_reset();
    write_entry(0, 32'h1000, 32'h8000, 1, 0);
    for (int k = 0; k < 5; k++) send(32'h1000, mk(1, 0, 32'h8000));
    drain();
    n_checks++; if (ctl_hit_cnt_o !== 2'd3) $display("FAIL cnt_saturate: got %0d want 3", ctl_hit_cnt_o); else n_pass++;
    ctl_hit_clr_i = 1'b1;
    send(32'h1000, mk(1, 0, 32'h8000));
    ctl_hit_clr_i = 1'b0;
    n_checks++; if (ctl_hit_cnt_o !== 2'd0) $display("FAIL cnt_clear_hit: got %0d want 0", ctl_hit_cnt_o); else n_pass++;
    send(32'h1000, mk(1, 0, 32'h8000));
    send(32'h1004, mk(0, 0, 32'h1004));
    n_checks++; if (ctl_hit_cnt_o !== 2'd1) $display("FAIL cnt_after_clear: got %0d want 1", ctl_hit_cnt_o); else n_pass++;
    drain();
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rand_mode = 0;
    rst_i     = 1'b1;
    test_reset();
    test_passthrough();
    test_hit_priority();
    test_oneshot();
    test_write_timing();
    test_backpressure();
    test_random_traffic();
    test_reset_mid_transfer();
`ifdef APU_HIT_CNT_EN
    test_hit_counter();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
